cpu_control_unit: RTL and testbench
===================================

# cpu_control_unit

Instruction sequencer for the Salamander-4 datapath. It fetches 12-bit instructions from a synchronous instruction memory and decodes them. It drives the combinational ALU directly upstream of it (CE, opcode, operands, carry-in) and commits the ALU result into an accumulator and flag registers. It also handles data-memory load/store, conditional jumps and halt.

## Interface
- SIZE, 8, data/accumulator width; must match the ALU SIZE.
- ADDR_W, 8, instruction and data address width; the instruction operand field is ADDR_W bits.
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  synchronous, active-low reset.
- imem_addr  out  ADDR_W  instruction fetch address (= PC).
- imem_rdata  in  4+ADDR_W  instruction word, valid one cycle after imem_addr; [11:8] opcode, [7:0] operand address.
- dmem_addr  out  ADDR_W  data address (= IR operand field).
- dmem_rdata  in  SIZE  read data, valid one cycle after dmem_addr.
- dmem_wdata  out  SIZE  store data.
- dmem_we  out  1  write strobe, one cycle.
- alu_ce  out  1  ALU enable.
- alu_op_code  out  4  ALU opcode (= IR[11:8]).
- alu_left  out  SIZE  accumulator.
- alu_right  out  SIZE  dmem_rdata.
- alu_carry_in  out  1  tied 0.
- alu_op_out  in  SIZE  ALU result.
- alu_carry_out  in  1  ALU carry.
- zero_flag, carry_flag  out  1 each  architectural flags.
- acc_out  out  SIZE  accumulator.
- pc_out  out  ADDR_W  program counter.
- halted  out  1  high in HALT state.

## Operation
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, LD=6, ST=7, INC=8, DEC=9, SHL=A, SHR=B, HLT=C, JZ=D, JNZ=E, NOP=F. All 16 values are defined.
- FSM states are FETCH → DECODE → MEMRD → EXECUTE → FETCH. HLT enters HALT, which is left only by reset.
  - FETCH: imem_addr=PC.
  - DECODE: IR <= imem_rdata.
  - MEMRD: dmem_addr=IR[7:0].
  - EXECUTE: dmem_rdata is valid; results are committed at the end of the cycle.
- alu_ce=1 only in EXECUTE and only for opcodes 0x0–0xB. It is 0 in every other state and for opcodes C–F.
- Accumulator writes:
  - ADD, SUB, AND, OR, XOR, NOT, LD, INC, DEC, SHL and SHR write acc <= alu_op_out.
  - ST, HLT, JZ, JNZ and NOP leave acc unchanged.
  - acc never captures an x-valued ALU output.
- ST: dmem_we=1 in EXECUTE, with dmem_wdata=acc and dmem_addr=IR[7:0].
- Zero flag: zero_flag <= (alu_op_out==0) on every instruction that writes acc. It holds otherwise.
- The zero flag is computed internally from the result, not taken from the ALU.
- Carry flag: carry_flag <= alu_carry_out on ADD and SUB only. It holds otherwise.
- Arithmetic is modulo 2^SIZE. SUB computes acc − mem with carry_in=0.
- PC update at the end of EXECUTE:
  - JZ with zero_flag=1, or JNZ with zero_flag=0: PC <= IR[7:0].
  - Otherwise: PC <= PC+1, wrapping 0xFF→0x00.
  - The jump test uses the flag value before this instruction; JZ and JNZ never modify flags.
- HLT: PC is not incremented and halted=1. All strobes stay 0 and all registers hold.

## Timing
- Every instruction takes exactly 4 cycles, including jumps and NOP.
- Instruction n+1 FETCH starts the cycle after instruction n EXECUTE.
- Reset values: PC=0, IR=0, acc=0, zero_flag=0, carry_flag=0, state=FETCH, halted=0, alu_ce=0, dmem_we=0, imem_addr=0.
- Reset in any state, including HALT and mid-EXECUTE:
  - RST_N=0 gates dmem_we and alu_ce to 0 in the same cycle.
  - No register commits from the interrupted instruction.
  - The first FETCH of PC=0 is in the cycle after RST_N rises.
- dmem_we is a 1-cycle pulse per ST. It is never asserted outside EXECUTE.
- ALU inputs are stable for the whole EXECUTE cycle. The result is sampled at the rising edge ending EXECUTE.

## Test plan
- Reset/idle: hold RST_N=0 for 3 cycles → all outputs at reset values. Release → imem_addr=0 on the first cycle, then 1 after 4 cycles with a NOP stream.
- Load/add/store: mem[0x10]=0x7F, mem[0x11]=0x81. Program LD 10; ADD 11; ST 12 → acc=0x00, carry_flag=1, zero_flag=1, mem[0x12]=0x00, with one dmem_we pulse in cycle 12.
- Branches: with zero_flag=1, JZ 0x20 → PC=0x20. With zero_flag=0, JZ 0x20 → PC increments. JNZ does the opposite. Flags are unchanged in all cases.
- Halt/wrap:
  - NOPs from PC=0xFF → next PC=0x00.
  - HLT at 0x05 → halted=1, PC stays 0x05 for 20 cycles, no alu_ce or dmem_we.
- Reset mid-ST: assert RST_N=0 during the EXECUTE of ST → dmem_we never rises, memory is unchanged, and PC=0 after reset.
- Full opcode sweep: acc=0x80 and operand 0x01 through AND/OR/XOR/NOT/INC/DEC/SHL/SHR → acc and zero_flag match the reference model, and carry_flag is unchanged.

Source files
------------

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: 4-cycle fetch/decode/memrd/execute sequencer driving an external ALU.
// Owns PC, IR, accumulator and flags; handles load/store, conditional jumps and halt.
module cpu_control_unit #(
  parameter int SIZE   = 8,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [ADDR_W+3:0] imem_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  input  logic [SIZE-1:0]   dmem_rdata,
  output logic [SIZE-1:0]   dmem_wdata,
  output logic              dmem_we,
  output logic              alu_ce,
  output logic [3:0]        alu_op_code,
  output logic [SIZE-1:0]   alu_left,
  output logic [SIZE-1:0]   alu_right,
  output logic              alu_carry_in,
  input  logic [SIZE-1:0]   alu_op_out,
  input  logic              alu_carry_out,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic [SIZE-1:0]   acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_MEMRD, S_EXEC, S_HALT} state_t;
  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W+3:0]   r_ir;
  logic [SIZE-1:0]     r_acc;
  logic                r_zf, r_cf;
  logic [3:0]          w_op;
  logic [ADDR_W-1:0]   w_opnd;
  logic                w_exec, w_acc_wr, w_jump;
  assign w_op     = r_ir[ADDR_W+3:ADDR_W];
  assign w_opnd   = r_ir[ADDR_W-1:0];
  assign w_exec   = r_state == S_EXEC;
  assign w_acc_wr = w_op < 4'hC && w_op != 4'h7;
  // jump test uses the flag as it stood before this instruction
  assign w_jump   = (w_op == 4'hD && r_zf) || (w_op == 4'hE && !r_zf);
  always_ff @(posedge CLK)
    if (!RST_N) r_state <= S_FETCH;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state == S_FETCH  ? S_DECODE :
             r_state == S_DECODE ? S_MEMRD  :
             r_state == S_MEMRD  ? S_EXEC   :
             r_state == S_EXEC   ? (w_op == 4'hC ? S_HALT : S_FETCH) : S_HALT;
  end
  always_ff @(posedge CLK)
    if (!RST_N) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_acc <= '0;
      r_zf  <= 1'b0;
      r_cf  <= 1'b0;
    end else begin
      if (r_state == S_DECODE) r_ir <= imem_rdata;
      if (w_exec && w_op != 4'hC) r_pc <= w_jump ? w_opnd : r_pc + 1'b1;
      if (w_exec && w_acc_wr) begin
        r_acc <= alu_op_out;
        r_zf  <= alu_op_out == '0;
      end
      if (w_exec && w_op <= 4'h1) r_cf <= alu_carry_out;
    end
  always_comb begin
    imem_addr    = r_pc;
    dmem_addr    = w_opnd;
    dmem_wdata   = r_acc;
    dmem_we      = RST_N && w_exec && w_op == 4'h7;
    alu_ce       = RST_N && w_exec && w_op < 4'hC;
    alu_op_code  = w_op;
    alu_left     = r_acc;
    alu_right    = dmem_rdata;
    alu_carry_in = 1'b0;
    zero_flag    = r_zf;
    carry_flag   = r_cf;
    acc_out      = r_acc;
    pc_out       = r_pc;
    halted       = r_state == S_HALT;
  end
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: directed bench with behavioural instruction/data memories and ALU model.
module tb_cpu_control_unit;
  logic       CLK = 1'b0, RST_N = 1'b0;
  logic [7:0] imem_addr, dmem_addr, dmem_rdata, dmem_wdata;
  logic [11:0] imem_rdata;
  logic       dmem_we, alu_ce, alu_carry_in, alu_carry_out, zero_flag, carry_flag, halted;
  logic [3:0] alu_op_code;
  logic [7:0] alu_left, alu_right, alu_op_out, acc_out, pc_out;
  logic [11:0] imem [256];
  logic [7:0]  dmem [256];
  logic        tb_we = 1'b0;
  logic [7:0]  tb_a = '0, tb_d = '0;
  logic [8:0]  t;
  int n_tests = 0, n_fail = 0;

  cpu_control_unit #(.SIZE(8), .ADDR_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .alu_ce(alu_ce), .alu_op_code(alu_op_code), .alu_left(alu_left), .alu_right(alu_right),
    .alu_carry_in(alu_carry_in), .alu_op_out(alu_op_out), .alu_carry_out(alu_carry_out),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .acc_out(acc_out), .pc_out(pc_out),
    .halted(halted));

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    imem_rdata <= imem[imem_addr];
    dmem_rdata <= dmem[dmem_addr];
    if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
    else if (tb_we) dmem[tb_a] <= tb_d;
  end

  // ALU model; a disabled ALU returns a poison value the DUT must never commit
  always_comb begin
    t = 9'h0;
    case (alu_op_code)
      4'h0: t = {1'b0, alu_left} + {1'b0, alu_right};
      4'h1: t = {1'b0, alu_left} - {1'b0, alu_right};
      4'h2: t = {1'b0, alu_left & alu_right};
      4'h3: t = {1'b0, alu_left | alu_right};
      4'h4: t = {1'b0, alu_left ^ alu_right};
      4'h5: t = {1'b0, ~alu_left};
      4'h6: t = {1'b0, alu_right};
      4'h8: t = {1'b0, alu_left + 8'h1};
      4'h9: t = {1'b0, alu_left - 8'h1};
      4'hA: t = {1'b0, alu_left << 1};
      4'hB: t = {1'b0, alu_left >> 1};
      default: t = 9'h0;
    endcase
    alu_op_out    = alu_ce ? t[7:0] : 8'hEE;
    alu_carry_out = alu_ce ? t[8] : 1'b1;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    tb_a = a; tb_d = d; tb_we = 1'b1;
    tick;
    tb_we = 1'b0;
  endtask

  task automatic clear_imem;
    for (int i = 0; i < 256; i++) imem[i] = 12'hF00;
  endtask

  task automatic start;
    RST_N = 1'b0;
    repeat (3) tick;
    RST_N = 1'b1;
  endtask

  logic [3:0] sw_op  [8] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  logic [7:0] sw_acc [8] = '{8'h00, 8'h81, 8'h81, 8'h7F, 8'h81, 8'h7F, 8'h00, 8'h40};
  logic       sw_z   [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int we_cnt, we_cyc, viol;
    logic [7:0] acc_ld;
    clear_imem();
    #1;
    poke(8'h10, 8'h7F); poke(8'h11, 8'h81); poke(8'h12, 8'hAA); poke(8'h13, 8'h05);
    poke(8'h14, 8'h3C); poke(8'h30, 8'h80); poke(8'h31, 8'h01); poke(8'h32, 8'h80);
    repeat (3) tick;
    chk("rst_pc", pc_out, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_zf", zero_flag, 0);
    chk("rst_cf", carry_flag, 0);
    chk("rst_halted", halted, 0);
    chk("rst_alu_ce", alu_ce, 0);
    chk("rst_dmem_we", dmem_we, 0);
    RST_N = 1'b1;
    chk("idle_addr_c1", imem_addr, 0);
    repeat (3) tick;
    chk("nop_exec_ce", alu_ce, 0);
    chk("nop_exec_we", dmem_we, 0);
    chk("carry_in", alu_carry_in, 0);
    tick;
    chk("idle_addr_c5", imem_addr, 1);

    clear_imem();
    imem[0] = 12'h610; imem[1] = 12'h011; imem[2] = 12'h712; imem[3] = 12'hD20;
    imem[8'h20] = 12'hE40; imem[8'h21] = 12'h613; imem[8'h22] = 12'hD30;
    imem[8'h23] = 12'hE50; imem[8'h50] = 12'hC00;
    start();
    we_cnt = 0; we_cyc = 0; acc_ld = '0;
    for (int c = 1; c <= 12; c++) begin
      if (dmem_we) begin we_cnt++; we_cyc = c; end
      if (c == 5) acc_ld = acc_out;
      tick;
    end
    chk("ld_acc", acc_ld, 8'h7F);
    chk("add_acc", acc_out, 8'h00);
    chk("add_cf", carry_flag, 1);
    chk("add_zf", zero_flag, 1);
    chk("st_mem", dmem[8'h12], 8'h00);
    chk("st_we_count", we_cnt, 1);
    chk("st_we_cycle", we_cyc, 12);
    repeat (4) tick;
    chk("jz_taken_pc", pc_out, 8'h20);
    chk("jz_taken_zf", zero_flag, 1);
    chk("jz_taken_cf", carry_flag, 1);
    repeat (4) tick;
    chk("jnz_nt_pc", pc_out, 8'h21);
    chk("jnz_nt_zf", zero_flag, 1);
    repeat (4) tick;
    chk("ld2_acc", acc_out, 8'h05);
    chk("ld2_zf", zero_flag, 0);
    chk("ld2_cf", carry_flag, 1);
    repeat (4) tick;
    chk("jz_nt_pc", pc_out, 8'h23);
    chk("jz_nt_zf", zero_flag, 0);
    repeat (4) tick;
    chk("jnz_taken_pc", pc_out, 8'h50);
    chk("jnz_taken_zf", zero_flag, 0);
    chk("jnz_taken_cf", carry_flag, 1);
    repeat (4) tick;
    chk("hlt50_halted", halted, 1);
    chk("hlt50_pc", pc_out, 8'h50);

    clear_imem();
    imem[0] = 12'hEFF;
    start();
    repeat (4) tick;
    chk("wrap_pre_pc", pc_out, 8'hFF);
    repeat (4) tick;
    chk("wrap_pc", pc_out, 8'h00);

    clear_imem();
    imem[5] = 12'hC00;
    start();
    repeat (20) tick;
    chk("hlt_pre_halted", halted, 0);
    chk("hlt_pre_pc", pc_out, 8'h05);
    repeat (4) tick;
    chk("hlt_halted", halted, 1);
    viol = 0;
    for (int c = 0; c < 20; c++) begin
      if (alu_ce || dmem_we || pc_out != 8'h05 || !halted) viol++;
      tick;
    end
    chk("hlt_hold_viol", viol, 0);
    chk("hlt_hold_pc", pc_out, 8'h05);
    RST_N = 1'b0;
    tick;
    chk("hlt_rst_halted", halted, 0);
    chk("hlt_rst_pc", pc_out, 0);

    clear_imem();
    imem[0] = 12'h610; imem[1] = 12'h714;
    start();
    repeat (7) tick;
    chk("midst_opcode", alu_op_code, 4'h7);
    RST_N = 1'b0;
    #1;
    chk("midst_we_gated", dmem_we, 0);
    chk("midst_ce_gated", alu_ce, 0);
    tick;
    chk("midst_mem", dmem[8'h14], 8'h3C);
    chk("midst_pc", pc_out, 0);
    chk("midst_acc", acc_out, 0);
    RST_N = 1'b1;
    chk("midst_fetch_addr", imem_addr, 0);

    clear_imem();
    imem[0] = 12'h630; imem[1] = 12'h032;
    for (int k = 0; k < 8; k++) begin
      imem[2 + 2 * k] = 12'h630;
      imem[3 + 2 * k] = {sw_op[k], 8'h31};
    end
    start();
    repeat (8) tick;
    chk("sweep_setup_cf", carry_flag, 1);
    chk("sweep_setup_acc", acc_out, 8'h00);
    for (int k = 0; k < 8; k++) begin
      repeat (8) tick;
      chk($sformatf("sweep_acc_op%0h", sw_op[k]), acc_out, sw_acc[k]);
      chk($sformatf("sweep_zf_op%0h", sw_op[k]), zero_flag, sw_z[k]);
      chk($sformatf("sweep_cf_op%0h", sw_op[k]), carry_flag, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
